dac_spi_tx: RTL and testbench

- Serializer stage directly downstream of the DAC AXI4-Lite register block.
- Accepts 16-bit DAC sample words over a valid/ready stream and buffers them in a small FIFO.
- Shifts each word out MSB-first to an external SPI DAC (SYNC_n / SCLK / DIN, DAC121S101-style) with programmable SCLK rate and inter-frame gap.
- Used to drive the EIT excitation DAC.

---
 rtl/dac_spi_tx.sv | 218 +++++++++++++++++++++
 tb/tb_dac_spi_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// SPI DAC serializer: FIFO-buffered 16-bit samples shifted MSB-first on SYNC_n/SCLK/DIN.
// Optional LDAC_n strobe during the inter-frame gap when DAC_SPI_TX_LDAC_EN is defined.
module dac_spi_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [DATA_WIDTH-1:0]         s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          dac_sclk,
   output logic                          dac_sync_n,
   output logic                          dac_din,
   output logic                          busy,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef DAC_SPI_TX_LDAC_EN
   ,output logic                         dac_ldac_n
`endif
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int DIV_W  = $clog2(CLK_DIV) + 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
   localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(FIFO_DEPTH);

   generate
      if (CLK_DIV < 1) begin : g_bad_div
         $error("CLK_DIV must be >= 1");
      end
      if (GAP_CYCLES < 1) begin : g_bad_gap
         $error("GAP_CYCLES must be >= 1");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of 2 and >= 2");
      end
`ifdef DAC_SPI_TX_LDAC_EN
      if (GAP_CYCLES < CLK_DIV + 2) begin : g_bad_ldac_gap
         $error("GAP_CYCLES must be >= CLK_DIV+2 when LDAC is enabled");
      end
`endif
   endgenerate

   // ---------------- input FIFO ----------------
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W:0]       wr_ptr_reg, rd_ptr_reg;
   logic [ADDR_W:0]       level;
   logic                  full, empty, push, pop;
   logic [DATA_WIDTH-1:0] head;

   assign level      = wr_ptr_reg - rd_ptr_reg;
   assign full       = (level == FULL_LVL);
   assign empty      = (level == '0);
   assign s_ready    = !full;
   assign push       = s_valid && !full;
   assign head       = mem[rd_ptr_reg[ADDR_W-1:0]];
   assign fifo_level = level;

   always_ff @(posedge ACLK) begin
      if (push) mem[wr_ptr_reg[ADDR_W-1:0]] <= s_data;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // ---------------- serializer FSM ----------------
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

   state_t                state_reg, state_next;
   logic [DIV_W-1:0]      div_reg, div_next;
   logic                  phase_reg, phase_next;   // 0: SCLK high half, 1: SCLK low half
   logic [BIT_W-1:0]      bit_reg, bit_next;
   logic [GAP_W-1:0]      gap_reg, gap_next;
   logic [DATA_WIDTH-1:0] sh_reg, sh_next;
   logic                  sclk_reg, sclk_next;
   logic                  sync_n_reg, sync_n_next;
   logic                  din_reg, din_next;
   logic                  done_reg, done_next;
   logic                  start_frame;

   always_comb begin
      state_next  = state_reg;
      div_next    = div_reg;
      phase_next  = phase_reg;
      bit_next    = bit_reg;
      gap_next    = gap_reg;
      sh_next     = sh_reg;
      sclk_next   = sclk_reg;
      sync_n_next = sync_n_reg;
      din_next    = din_reg;
      done_next   = 1'b0;
      start_frame = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!empty) start_frame = 1'b1;
         end
         SETUP: begin
            if (div_reg == DIV_LAST) begin
               state_next = SHIFT;
               div_next   = '0;
               phase_next = 1'b0;
               bit_next   = '0;
            end else begin
               div_next = div_reg + 1'b1;
            end
         end
         SHIFT: begin
            if (div_reg != DIV_LAST) begin
               div_next = div_reg + 1'b1;
            end else begin
               div_next = '0;
               if (!phase_reg) begin
                  phase_next = 1'b1;
                  sclk_next  = 1'b0;
               end else begin
                  phase_next = 1'b0;
                  sclk_next  = 1'b1;
                  if (bit_reg == BIT_LAST) begin
                     sync_n_next = 1'b1;
                     done_next   = 1'b1;
                     state_next  = GAP;
                     gap_next    = '0;
                  end else begin
                     bit_next = bit_reg + 1'b1;
                     sh_next  = {sh_reg[DATA_WIDTH-2:0], 1'b0};
                     din_next = sh_reg[DATA_WIDTH-2];
                  end
               end
            end
         end
         GAP: begin
            if (gap_reg == GAP_LAST) begin
               if (!empty) start_frame = 1'b1;
               else        state_next  = IDLE;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Popping the head and opening the frame share one path from IDLE and GAP
      if (start_frame) begin
         state_next  = SETUP;
         sh_next     = head;
         din_next    = head[DATA_WIDTH-1];
         sync_n_next = 1'b0;
         sclk_next   = 1'b1;
         div_next    = '0;
      end
      pop = start_frame;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_reg  <= IDLE;
         div_reg    <= '0;
         phase_reg  <= 1'b0;
         bit_reg    <= '0;
         gap_reg    <= '0;
         sh_reg     <= '0;
         sclk_reg   <= 1'b1;
         sync_n_reg <= 1'b1;
         din_reg    <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         div_reg    <= div_next;
         phase_reg  <= phase_next;
         bit_reg    <= bit_next;
         gap_reg    <= gap_next;
         sh_reg     <= sh_next;
         sclk_reg   <= sclk_next;
         sync_n_reg <= sync_n_next;
         din_reg    <= din_next;
         done_reg   <= done_next;
      end
   end

   assign dac_sclk   = sclk_reg;
   assign dac_sync_n = sync_n_reg;
   assign dac_din    = din_reg;
   assign frame_done = done_reg;
   assign busy       = (state_reg != IDLE);

`ifdef DAC_SPI_TX_LDAC_EN
   // Low for the CLK_DIV cycles following the first GAP cycle
   logic ldac_n_reg, ldac_n_next;

   always_comb begin
      ldac_n_next = !((state_reg == GAP) && (gap_reg < GAP_W'(CLK_DIV)));
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) ldac_n_reg <= 1'b1;
      else        ldac_n_reg <= ldac_n_next;
   end

   assign dac_ldac_n = ldac_n_reg;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default instance plus a CLK_DIV=1 instance, frames decoded off the pins.
module tb_dac_spi_tx;

`ifdef DAC_SPI_TX_LDAC_EN
   localparam int FAST_GAP = 3;
`else
   localparam int FAST_GAP = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, s_valid, s_ready, sclk, sync_n, din, busy, frame_done;
   logic [15:0] s_data;
   logic [2:0]  fifo_level;
   logic        ldac_n;

   logic        f_rst, f_valid, f_ready, f_sclk, f_sync_n, f_din, f_busy, f_done;
   logic [15:0] f_data;
   logic [2:0]  f_level;
   logic        f_ldac_n;

   dac_spi_tx u_dut (
      .ACLK(clk), .ARESET(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .dac_sclk(sclk), .dac_sync_n(sync_n), .dac_din(din), .busy(busy),
      .frame_done(frame_done), .fifo_level(fifo_level)
`ifdef DAC_SPI_TX_LDAC_EN
      , .dac_ldac_n(ldac_n)
`endif
   );

   dac_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(FAST_GAP)) u_fast (
      .ACLK(clk), .ARESET(f_rst), .s_data(f_data), .s_valid(f_valid), .s_ready(f_ready),
      .dac_sclk(f_sclk), .dac_sync_n(f_sync_n), .dac_din(f_din), .busy(f_busy),
      .frame_done(f_done), .fifo_level(f_level)
`ifdef DAC_SPI_TX_LDAC_EN
      , .dac_ldac_n(f_ldac_n)
`endif
   );

`ifndef DAC_SPI_TX_LDAC_EN
   assign ldac_n   = 1'b1;
   assign f_ldac_n = 1'b1;
`endif

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- pin-level frame monitor for u_dut ----------------
   logic [15:0] q_word[$];
   int          q_bits[$];
   int          q_low[$];
   int          q_gap[$];
   int          q_ldelay[$];
   int          q_llen[$];
   int          m_starts = 0, m_fd = 0, m_busy = 0, m_nbits = 0;

   initial begin
      logic        prev_sync, prev_sclk, prev_ldac, seen;
      logic [15:0] word;
      int          low, high, since_rise, lrun;
      prev_sync = 1'b1; prev_sclk = 1'b1; prev_ldac = 1'b1; seen = 1'b0;
      word = '0; low = 0; high = 0; since_rise = 0; lrun = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_sync = 1'b1; prev_sclk = 1'b1; prev_ldac = 1'b1; seen = 1'b0;
            word = '0; m_nbits = 0; low = 0; high = 0;
         end else begin
            if (busy) m_busy++;
            if (frame_done) m_fd++;
            if (!sync_n && prev_sync) begin
               m_starts++;
               if (seen) q_gap.push_back(high);
               word = '0; m_nbits = 0; low = 0;
            end
            if (!sync_n) low++;
            if (!sync_n && prev_sclk && !sclk) begin
               word = {word[14:0], din};
               m_nbits++;
            end
            if (sync_n && !prev_sync) begin
               q_word.push_back(word);
               q_bits.push_back(m_nbits);
               q_low.push_back(low);
               $display("frame word=0x%04h bits=%0d sync_low=%0d", word, m_nbits, low);
               seen = 1'b1;
               high = 1;
               since_rise = 0;
            end else begin
               if (sync_n) high++;
               since_rise++;
            end
            if (!ldac_n && prev_ldac) begin
               q_ldelay.push_back(since_rise);
               lrun = 0;
            end
            if (!ldac_n) lrun++;
            if (ldac_n && !prev_ldac) q_llen.push_back(lrun);
            prev_sync = sync_n; prev_sclk = sclk; prev_ldac = ldac_n;
         end
      end
   end

   logic [15:0] stim [8];

   // Holds s_valid high and offers stim[0..n-1]; cycles returns edges spent
   task automatic push_n(input int n, output int cycles);
      int   i;
      logic rdy;
      i = 0;
      cycles = 0;
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = stim[0];
      while (i < n && cycles < 500) begin
         @(negedge clk);
         rdy = s_ready;
         @(posedge clk); #1;
         cycles++;
         if (rdy) begin
            $display("push word=0x%04h", stim[i]);
            i++;
            if (i < n) s_data = stim[i];
         end
      end
      s_valid = 1'b0;
      check("push_accepts", i, n);
   endtask

   initial begin
      int b_q, b_g, b_fd, b_busy, b_starts, b_l, cyc, n_full, bad_lvl, guard;
      int fb, fs, ff, ftg;
      logic        fprev_sclk;
      logic [15:0] fword;

      rst = 1'b1; s_valid = 1'b0; s_data = '0;
      f_rst = 1'b1; f_valid = 1'b0; f_data = '0;
      #2;
      check("rst_sclk", sclk, 1);
      check("rst_sync_n", sync_n, 1);
      check("rst_din", din, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_level", fifo_level, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; f_rst = 1'b0;
      #1 check("rst_s_ready", s_ready, 1);

      // ---- single word 0xA5C3 ----
      b_q = q_word.size(); b_fd = m_fd; b_busy = m_busy; b_l = q_llen.size();
      @(posedge clk); #1;
      s_data = 16'hA5C3; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      $display("push word=0x%04h", s_data);
      check("lat_level_after_push", fifo_level, 1);
      check("lat_sync_still_high", sync_n, 1);
      @(posedge clk); #1;
      check("lat_sync_fall", sync_n, 0);
      check("lat_level_after_pop", fifo_level, 0);
      repeat (200) @(posedge clk); #1;
      check("t1_frame_count", q_word.size() - b_q, 1);
      check("t1_word", q_word[b_q], 16'hA5C3);
      check("t1_bits", q_bits[b_q], 16);
      check("t1_sync_low", q_low[b_q], 132);
      check("t1_frame_done", m_fd - b_fd, 1);
      check("t1_busy_cycles", m_busy - b_busy, 140);
      check("t1_idle", busy, 0);
`ifdef DAC_SPI_TX_LDAC_EN
      check("ldac_pulses", q_llen.size() - b_l, 1);
      check("ldac_delay", q_ldelay[b_l], 1);
      check("ldac_len", q_llen[b_l], 4);
`endif

      // ---- back-to-back five words ----
      stim[0] = 16'h0001; stim[1] = 16'h8000; stim[2] = 16'hFFFF;
      stim[3] = 16'h0000; stim[4] = 16'h1234;
      b_q = q_word.size(); b_g = q_gap.size(); b_fd = m_fd;
      push_n(5, cyc);
      check("t2_no_stall", cyc, 5);
      check("t2_ready_low", s_ready, 0);
      check("t2_level_full", fifo_level, 4);
      repeat (800) @(posedge clk); #1;
      check("t2_frame_count", q_word.size() - b_q, 5);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t2_word%0d", k), q_word[b_q + k], stim[k]);
      end
      for (int k = 1; k < 5; k++) begin
         check($sformatf("t2_gap%0d", k), q_gap[b_g + k], 8);
      end
      check("t2_frame_done", m_fd - b_fd, 5);
      check("t2_level_empty", fifo_level, 0);

      // ---- full FIFO, hold 0x7777 until a pop frees a slot ----
      stim[0] = 16'h1111; stim[1] = 16'h2222; stim[2] = 16'h3333;
      stim[3] = 16'h4444; stim[4] = 16'h5555;
      b_q = q_word.size();
      push_n(5, cyc);
      s_data = 16'h7777; s_valid = 1'b1;
      n_full = 0; bad_lvl = 0;
      for (guard = 0; guard < 400; guard++) begin
         @(negedge clk);
         if (s_ready) break;
         n_full++;
         if (fifo_level != 3'd4) bad_lvl++;
      end
      check("t3_full_cycles", n_full, 137);
      check("t3_level_held", bad_lvl, 0);
      check("t3_level_after_pop", fifo_level, 3);
      @(posedge clk); #1;
      s_valid = 1'b0;
      $display("push word=0x%04h", s_data);
      check("t3_level_after_accept", fifo_level, 4);
      repeat (900) @(posedge clk); #1;
      check("t3_frame_count", q_word.size() - b_q, 6);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t3_word%0d", k), q_word[b_q + k], stim[k]);
      end
      check("t3_word_late", q_word[b_q + 5], 16'h7777);

      // ---- reset at bit 7 of 0xFFFF with two words queued ----
      stim[0] = 16'hFFFF; stim[1] = 16'hAAAA; stim[2] = 16'h5555;
      push_n(3, cyc);
      for (guard = 0; guard < 300 && m_nbits < 7; guard++) begin
         @(posedge clk); #1;
      end
      check("t4_reach_bit7", m_nbits, 7);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("t4_sync_n", sync_n, 1);
      check("t4_sclk", sclk, 1);
      check("t4_din", din, 0);
      check("t4_level", fifo_level, 0);
      check("t4_busy", busy, 0);
      b_starts = m_starts; b_fd = m_fd;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (300) @(posedge clk); #1;
      check("t4_no_new_frame", m_starts - b_starts, 0);
      check("t4_no_frame_done", m_fd - b_fd, 0);
      check("t4_level_after", fifo_level, 0);

      // ---- CLK_DIV=1 instance, word 0x8001 ----
      @(posedge clk); #1;
      f_data = 16'h8001; f_valid = 1'b1;
      @(posedge clk); #1;
      f_valid = 1'b0;
      $display("push fast word=0x%04h", f_data);
      fb = 0; fs = 0; ff = 0; ftg = 0; fword = '0; fprev_sclk = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (f_busy) fb++;
         if (!f_sync_n) begin
            fs++;
            if (fs > 1 && f_sclk != fprev_sclk) ftg++;
            if (fprev_sclk && !f_sclk) begin
               fword = {fword[14:0], f_din};
               ff++;
            end
         end
         fprev_sclk = f_sclk;
      end
      $display("frame fast word=0x%04h bits=%0d sync_low=%0d", fword, ff, fs);
      check("t5_word", fword, 16'h8001);
      check("t5_bits", ff, 16);
      check("t5_sync_low", fs, 33);
      check("t5_sclk_toggles", ftg, 31);
      check("t5_period", fb, 33 + FAST_GAP);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
